ov7670_stream_gen: RTL and testbench
====================================

Name: ov7670_stream_gen

Overview:
- Transmit-side model of the OV7670 parallel video interface: reads RGB565 pixels from a frame buffer and emits the camera byte stream (vsync, href, data[7:0]), high byte first, one byte per tick.
- Used for camera-less loopback testing.
- Drives the capture path directly, so the full capture → frame buffer → display chain can be exercised with a known image.

Parameters:
- H_ACTIVE, 320, active pixels per line (2*H_ACTIVE bytes with href=1).
- V_ACTIVE, 240, active lines per frame.
- H_BLANK, 144, bytes per line with href=0 after the active bytes.
- VSYNC_LINES, 3, lines with vsync=1 at frame start.
- VBP_LINES, 17, blank lines between vsync fall and the first active line.
- VFP_LINES, 10, blank lines after the last active line.
- AW, 17, frame-buffer address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  byte strobe (PCLK-equivalent enable); all timing state advances only when tick=1.
- run  in  1  1 = generate frames continuously; 0 = stop at the end of the current frame.
- rAddr  out  AW  frame-buffer read address.
- rData  in  16  frame-buffer read data, valid one clk after rAddr (synchronous BRAM).
- vsync  out  1  frame sync, active high.
- href  out  1  line valid; data is meaningful only while href=1.
- data  out  8  pixel byte.
- frame_done  out  1  one-clk pulse on the tick that ends the last VFP line.

Behaviour:
- Reset values:
  - state=IDLE; vsync=0, href=0, data=0, rAddr=0, frame_done=0.
  - Line, column and pixel counters all 0.
- States:
  - IDLE
  - VSYNC (VSYNC_LINES lines)
  - VBACK (VBP_LINES lines)
  - ACTIVE (V_ACTIVE lines)
  - VFRONT (VFP_LINES lines)
- Line timing (all non-IDLE states):
  - Column counter col runs 0..LINE_BYTES-1 on ticks, LINE_BYTES = 2*H_ACTIVE + H_BLANK.
  - Line counter increments on the tick where col wraps.
  - A state transition occurs when the line counter reaches its state's count; the line counter then resets to 0.
- Transitions:
  - IDLE→VSYNC on a tick with run=1.
  - VSYNC→VBACK→ACTIVE→VFRONT at the line counts above.
  - VFRONT end: pulse frame_done, then go to VSYNC if run=1, else IDLE.
  - run is sampled only at VFRONT end and in IDLE; deasserting run mid-frame never truncates the frame.
- Outputs are registered and updated on ticks only; they hold between ticks.
  - vsync=1 exactly while state=VSYNC.
  - href=1 in ACTIVE when col<2*H_ACTIVE; otherwise href=0 and data=0.
  - Even col: data=pix[15:8]. Odd col: data=pix[7:0].
- Fetch pipeline:
  - pix is the 16-bit pixel register, loaded from rData on the tick that outputs each high byte.
  - rAddr advances by 1 on the tick that outputs each high byte, so the next pixel's data is settled ≥1 clk before it is needed.
  - On VSYNC entry: rAddr=0, and rAddr stays constant until the first active byte.
  - The first pixel of each line uses the address left by the previous line; no per-line reset.
  - After the last pixel of a frame, rAddr=H_ACTIVE*V_ACTIVE and is not read; it is cleared on the next VSYNC entry.
- Address width:
  - rAddr is a plain counter.
  - H_ACTIVE*V_ACTIVE must be ≤ 2^AW; this is checked by an elaboration-time assertion.
- tick back-to-back every clk is legal.
- Required: gap of ≥1 clk between the rAddr update and the next rData use, which the pipeline above guarantees.
- Reset asserted mid-line or mid-frame: return to the reset state within 1 clk; href and vsync drop immediately.

Decomposition:
- Package ov7670_pkg:
  - state enum gen_state_t {IDLE, VSYNC, VBACK, ACTIVE, VFRONT}.
  - RGB565 typedef pixel_t (16 bits).
  - Default timing constants, shared with the capture side.
- Sub-module ov7670_line_timer:
  - col/line counters and the line-end and state-end strobes, parameterised by line length.
- Top level holds the FSM, the fetch pipeline and the output registers.

Test Plan:
- Defaults, tick every clk, run=1; memory model returns rData=addr[15:0].
  - Expected: first href byte pair 0x00,0x00; second pair 0x00,0x01.
  - Expected: 320 pixels per line, 240 href pulses of 640 ticks each.
  - Expected: vsync high for 3*784 ticks.
- tick every 3rd clk, same image.
  - Expected: byte sequence identical to the previous case.
  - Expected: outputs change only on tick clks.
- run dropped mid-ACTIVE.
  - Expected: frame completes all 240 lines, frame_done pulses once, state returns to IDLE.
  - Expected: vsync stays 0 afterwards.
- Loopback to the capture block with H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, 1/1/1 blank lines.
  - Expected: the capture block writes addresses 0..7 with data equal to memory contents.
- Reset asserted on the 10th active byte.
  - Expected: next clk shows href=0, vsync=0, rAddr=0.
  - Expected: after release, the next frame starts again at pixel 0.
- Two back-to-back frames.
  - Expected: frame_done exactly once per frame.
  - Expected: rAddr=0 at the second VSYNC entry.
  - Expected: frame period (3+17+240+10)*784 ticks.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types and default timing for the OV7670 parallel video interface
// (the generator and the capture side both use these).
package ov7670_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } gen_state_t;

    typedef logic [15:0] pixel_t;

    localparam int DEF_H_ACTIVE    = 320;
    localparam int DEF_V_ACTIVE    = 240;
    localparam int DEF_H_BLANK     = 144;
    localparam int DEF_VSYNC_LINES = 3;
    localparam int DEF_VBP_LINES   = 17;
    localparam int DEF_VFP_LINES   = 10;
    localparam int DEF_AW          = 17;

    function automatic int max_lines(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ov7670_line_timer.sv
// Column/line position counters for the stream generator; col_next is the
// position the next tick moves to, so the caller can register outputs for it.
module ov7670_line_timer #(
    parameter int LINE_BYTES = 784,
    parameter int COL_W      = 10,
    parameter int LINE_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              running,
    input  logic [LINE_W-1:0] state_lines,
    output logic [COL_W-1:0]  col_next,
    output logic              state_end
);

    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;
    logic [LINE_W-1:0] line_next;
    logic              line_end;

    always_comb begin
        line_end  = running && (col == COL_W'(LINE_BYTES - 1));
        state_end = line_end && (line == state_lines - LINE_W'(1));
        col_next  = col;
        line_next = line;
        if (!running) begin
            col_next  = '0;
            line_next = '0;
        end else if (line_end) begin
            col_next  = '0;
            line_next = state_end ? '0 : line + LINE_W'(1);
        end else begin
            col_next  = col + COL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col  <= '0;
            line <= '0;
        end else if (tick) begin
            col  <= col_next;
            line <= line_next;
        end
    end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670-style byte stream generator: walks a frame buffer and emits
// vsync/href/data, high byte of each RGB565 pixel first, one byte per tick.
module ov7670_stream_gen
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int VBP_LINES   = DEF_VBP_LINES,
    parameter int VFP_LINES   = DEF_VFP_LINES,
    parameter int AW          = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          run,
    output logic [AW-1:0] rAddr,
    input  logic [15:0]   rData,
    output logic          vsync,
    output logic          href,
    output logic [7:0]    data,
    output logic          frame_done
);

    localparam int LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
    localparam int HREF_BYTES = 2 * H_ACTIVE;
    localparam int COL_W      = $clog2(LINE_BYTES);
    localparam int LINE_W     = $clog2(max_lines(VSYNC_LINES, VBP_LINES, V_ACTIVE, VFP_LINES) + 1);

    if (longint'(H_ACTIVE) * longint'(V_ACTIVE) > (longint'(1) << AW)) begin : g_aw_check
        $error("ov7670_stream_gen: H_ACTIVE*V_ACTIVE does not fit in AW address bits");
    end

    gen_state_t        state;
    gen_state_t        state_next;
    logic [LINE_W-1:0] state_lines;
    logic [COL_W-1:0]  col_next;
    logic              state_end;

    // Only the low byte is held: the high byte goes out on the same tick it is read.
    logic [7:0]        pix_lo;
    logic [7:0]        pix_lo_d;
    logic [AW-1:0]     addr_d;
    logic [7:0]        data_d;
    logic              vsync_d;
    logic              href_d;
    logic              done_d;

    always_comb begin
        state_lines = '0;
        unique case (state)
            VSYNC:   state_lines = LINE_W'(VSYNC_LINES);
            VBACK:   state_lines = LINE_W'(VBP_LINES);
            ACTIVE:  state_lines = LINE_W'(V_ACTIVE);
            VFRONT:  state_lines = LINE_W'(VFP_LINES);
            default: state_lines = '0;
        endcase
    end

    ov7670_line_timer #(
        .LINE_BYTES (LINE_BYTES),
        .COL_W      (COL_W),
        .LINE_W     (LINE_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .running     (state != IDLE),
        .state_lines (state_lines),
        .col_next    (col_next),
        .state_end   (state_end)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (tick) begin
            unique case (state)
                IDLE:    if (run)       state_next = VSYNC;
                VSYNC:   if (state_end) state_next = VBACK;
                VBACK:   if (state_end) state_next = ACTIVE;
                ACTIVE:  if (state_end) state_next = VFRONT;
                VFRONT:  if (state_end) state_next = run ? VSYNC : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs describe the position the tick moves into, so vsync/href line up with state.
    always_comb begin
        vsync_d  = (state_next == VSYNC);
        href_d   = 1'b0;
        data_d   = '0;
        pix_lo_d = pix_lo;
        addr_d   = rAddr;
        done_d   = (state == VFRONT) && state_end;
        if (state_next == VSYNC && state != VSYNC) addr_d = '0;
        if (state_next == ACTIVE && col_next < COL_W'(HREF_BYTES)) begin
            href_d = 1'b1;
            if (!col_next[0]) begin
                data_d   = rData[15:8];
                pix_lo_d = rData[7:0];
                addr_d   = rAddr + AW'(1);
            end else begin
                data_d   = pix_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync      <= 1'b0;
            href       <= 1'b0;
            data       <= '0;
            rAddr      <= '0;
            pix_lo     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= tick && done_d;
            if (tick) begin
                vsync  <= vsync_d;
                href   <= href_d;
                data   <= data_d;
                rAddr  <= addr_d;
                pix_lo <= pix_lo_d;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen on a reduced 4x2 image (10-byte lines,
// 2 vsync / 1 back-porch / 2 active / 1 front-porch lines = 60 ticks per frame).
module tb_ov7670_stream_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       run = 1'b0;
    logic [3:0] rAddr;
    logic [15:0] rData = '0;
    logic       vsync;
    logic       href;
    logic [7:0] data;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    ov7670_stream_gen #(
        .H_ACTIVE    (4),
        .V_ACTIVE    (2),
        .H_BLANK     (2),
        .VSYNC_LINES (2),
        .VBP_LINES   (1),
        .VFP_LINES   (1),
        .AW          (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .run        (run),
        .rAddr      (rAddr),
        .rData      (rData),
        .vsync      (vsync),
        .href       (href),
        .data       (data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous frame buffer: pixel a = {C,a,3,a}
    always @(posedge clk) rData <= {4'hC, rAddr, 4'h3, rAddr};

    logic [7:0] exp_bytes [16] = '{8'hC0, 8'h30, 8'hC1, 8'h31, 8'hC2, 8'h32, 8'hC3, 8'h33,
                                   8'hC4, 8'h34, 8'hC5, 8'h35, 8'hC6, 8'h36, 8'hC7, 8'h37};

    int bt, abs_t;
    int vs_cnt, hr_cnt, hr_pulses, hold_bad, early_addr, blank_data, first_vs_bt, first_href_bt;
    logic [7:0] bytes [$];
    int fd_at [$];
    int rise_abs [$];
    logic [3:0] addr_rise [$];
    logic prev_vsync, prev_href, prev_fd;
    logic [7:0] prev_data;
    logic [3:0] prev_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sync_prev();
        prev_vsync = vsync;
        prev_href  = href;
        prev_data  = data;
        prev_addr  = rAddr;
        prev_fd    = frame_done;
    endtask

    task automatic clear_stats();
        bt = 0; vs_cnt = 0; hr_cnt = 0; hr_pulses = 0; hold_bad = 0;
        early_addr = 0; blank_data = 0; first_vs_bt = -1; first_href_bt = -1;
        bytes.delete(); fd_at.delete(); addr_rise.delete();
    endtask

    // n ticks, one tick every div clks; samples 1 time unit after each edge
    task automatic run_ticks(input int n, input int div);
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < div; k++) begin
                tick = (k == div - 1);
                @(posedge clk);
                #1;
                if (tick) begin
                    if (vsync && !prev_vsync) begin
                        rise_abs.push_back(abs_t);
                        addr_rise.push_back(rAddr);
                        if (first_vs_bt < 0) first_vs_bt = bt;
                    end
                    if (vsync) vs_cnt++;
                    if (href) begin
                        if (!prev_href) hr_pulses++;
                        if (first_href_bt < 0) first_href_bt = bt;
                        hr_cnt++;
                        bytes.push_back(data);
                    end else if (data !== 8'h00) begin
                        blank_data++;
                    end
                    if (hr_cnt == 0 && rAddr !== 4'd0) early_addr++;
                    if (frame_done) fd_at.push_back(bt);
                    bt++;
                    abs_t++;
                end else begin
                    if (vsync !== prev_vsync || href !== prev_href || data !== prev_data ||
                        rAddr !== prev_addr || frame_done !== 1'b0)
                        hold_bad++;
                end
                sync_prev();
            end
        end
        tick = 1'b0;
    endtask

    task automatic check_bytes(input string tag);
        logic [31:0] obs;
        chk({tag, "_nbytes"}, bytes.size(), 16);
        for (int i = 0; i < 16; i++) begin
            obs = (i < bytes.size()) ? 32'(bytes[i]) : 'x;
            chk($sformatf("%s_b%0d", tag, i), obs, 32'(exp_bytes[i]));
        end
    endtask

    initial begin
        abs_t = 0;
        // Reset dominates run and tick
        reset = 1'b1; run = 1'b1; tick = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vsync", vsync, 0);
        chk("rst_href", href, 0);
        chk("rst_data", data, 0);
        chk("rst_addr", rAddr, 0);
        chk("rst_done", frame_done, 0);

        // Idle with run=0
        reset = 1'b0; run = 1'b0; tick = 1'b0;
        sync_prev();
        clear_stats();
        run_ticks(3, 1);
        chk("idle_vsync_cnt", vs_cnt, 0);
        chk("idle_href_cnt", hr_cnt, 0);

        // Frame 1, tick every clk
        run = 1'b1;
        clear_stats();
        run_ticks(60, 1);
        chk("f1_vsync_start", first_vs_bt, 0);
        chk("f1_vsync_ticks", vs_cnt, 20);
        chk("f1_first_href", first_href_bt, 30);
        chk("f1_href_pulses", hr_pulses, 2);
        chk("f1_href_ticks", hr_cnt, 16);
        chk("f1_early_addr", early_addr, 0);
        chk("f1_blank_data", blank_data, 0);
        chk("f1_no_done", fd_at.size(), 0);
        chk("f1_end_addr", rAddr, 8);
        check_bytes("f1");

        // Frame 2, back to back
        clear_stats();
        run_ticks(60, 1);
        chk("f2_done_cnt", fd_at.size(), 1);
        chk("f2_done_at", (fd_at.size() > 0) ? fd_at[0] : -1, 0);
        chk("f2_addr_at_vsync", (addr_rise.size() > 0) ? 32'(addr_rise[0]) : 'x, 0);
        chk("f2_period", (rise_abs.size() > 1) ? rise_abs[1] - rise_abs[0] : -1, 60);
        chk("f2_href_ticks", hr_cnt, 16);
        check_bytes("f2");

        // Frame 3, tick every third clk
        clear_stats();
        run_ticks(60, 3);
        chk("f3_hold", hold_bad, 0);
        chk("f3_vsync_ticks", vs_cnt, 20);
        chk("f3_first_href", first_href_bt, 30);
        chk("f3_done_cnt", fd_at.size(), 1);
        chk("f3_period", (rise_abs.size() > 2) ? rise_abs[2] - rise_abs[1] : -1, 60);
        check_bytes("f3");

        // Frame 4, run dropped mid-ACTIVE
        clear_stats();
        run_ticks(35, 1);
        chk("f4_mid_href", href, 1);
        run = 1'b0;
        run_ticks(26, 1);
        chk("f4_href_ticks", hr_cnt, 16);
        chk("f4_done_cnt", fd_at.size(), 2);
        chk("f4_done_at_end", (fd_at.size() > 1) ? fd_at[1] : -1, 60);
        chk("f4_end_vsync", vsync, 0);
        check_bytes("f4");
        clear_stats();
        run_ticks(20, 1);
        chk("idle2_vsync_cnt", vs_cnt, 0);
        chk("idle2_href_cnt", hr_cnt, 0);
        chk("idle2_done_cnt", fd_at.size(), 0);
        chk("idle2_addr_held", rAddr, 8);

        // Reset on the 10th active byte
        run = 1'b1;
        clear_stats();
        run_ticks(42, 1);
        chk("r_pre_href", href, 1);
        chk("r_pre_data", data, 8'h34);
        chk("r_pre_addr", rAddr, 5);
        reset = 1'b1; tick = 1'b0;
        @(posedge clk);
        #1;
        chk("r_href", href, 0);
        chk("r_vsync", vsync, 0);
        chk("r_addr", rAddr, 0);
        chk("r_data", data, 0);
        reset = 1'b0;
        sync_prev();
        clear_stats();
        run_ticks(60, 1);
        chk("r2_vsync_start", first_vs_bt, 0);
        chk("r2_first_href", first_href_bt, 30);
        check_bytes("r2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
